// File: rtl/edge_generator.sv
// Request-driven pulse generator: queues up to MAX_PENDING requests and emits one fixed-width pulse per request.
// Optional sticky overflow flag on port overflow_o when EDGE_GENERATOR_OVERFLOW_EN is defined.
module edge_generator #(
    parameter int HIGH_CYCLES = 2,
    parameter int LOW_CYCLES  = 2,
    parameter int MAX_PENDING = 4,
    parameter bit IDLE_LEVEL  = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               arst_ni,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    output logic                               q_o,
    output logic                               busy_o,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_o
`ifdef EDGE_GENERATOR_OVERFLOW_EN
    ,
    output logic                               overflow_o
`endif
);

    localparam int PW      = $clog2(MAX_PENDING + 1);
    localparam int CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RECOVER
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_nextCnt;
    logic [PW-1:0]   r_pending;
    logic            r_q;
    logic            w_accept;
    logic            w_start;

    assign req_ready_o = (r_pending < PEND_MAX);
    assign w_accept    = req_valid_i && req_ready_o;
    assign pending_o   = r_pending;
    assign q_o         = r_q;
    assign busy_o      = (r_state != IDLE) || (r_pending != '0);

    // The counter runs from 0 to the last cycle of the current phase; a new pulse may
    // start straight out of RECOVER so back-to-back pulses keep an exact period.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextCnt = '0;
                if (r_pending != '0) begin
                    w_nextState = ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (r_cnt == HIGH_LAST) begin
                    w_nextState = RECOVER;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            RECOVER: begin
                if (r_cnt == LOW_LAST) begin
                    w_nextCnt = '0;
                    if (r_pending != '0) begin
                        w_nextState = ACTIVE;
                        w_start     = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_q       <= IDLE_LEVEL;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_q     <= (w_nextState == ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
            case ({w_accept, w_start})
                2'b10:   r_pending <= r_pending + 1'b1;
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

`ifdef EDGE_GENERATOR_OVERFLOW_EN
    logic r_overflow;

    // Sticky: any dropped request is remembered until the next reset.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_overflow <= 1'b0;
        end else if (req_valid_i && !req_ready_o) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;
`endif

endmodule

// File: tb/tb_edge_generator.sv
// Randomized bench for edge_generator: two instances (idle-low and idle-high) share stimulus
// and are compared every cycle against a pulse-schedule model kept in the bench.
module tb_edge_generator;

    localparam int HIGH = 2;
    localparam int LOW  = 3;
    localparam int MAXP = 4;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clock = 1'b0;
    logic          arstN;
    logic          reqValid;
    logic          readyA, qA, busyA;
    logic          readyB, qB, busyB;
    logic [PW-1:0] pendA, pendB;
`ifdef EDGE_GENERATOR_OVERFLOW_EN
    logic          overflowA, overflowB;
`endif

    int errors = 0;
    int checks = 0;

    // Model: pulses are described only by the edge on which the latest one started.
    int mPending;
    int mLastStart;
    int lastEdge;
    bit mOverflow;

    always #5 clock = ~clock;

    edge_generator #(
        .HIGH_CYCLES(HIGH), .LOW_CYCLES(LOW), .MAX_PENDING(MAXP), .IDLE_LEVEL(1'b0)
    ) u_dut (
        .clk_i(clock), .arst_ni(arstN), .req_valid_i(reqValid), .req_ready_o(readyA),
        .q_o(qA), .busy_o(busyA), .pending_o(pendA)
`ifdef EDGE_GENERATOR_OVERFLOW_EN
        , .overflow_o(overflowA)
`endif
    );

    edge_generator #(
        .HIGH_CYCLES(HIGH), .LOW_CYCLES(LOW), .MAX_PENDING(MAXP), .IDLE_LEVEL(1'b1)
    ) u_dutInv (
        .clk_i(clock), .arst_ni(arstN), .req_valid_i(reqValid), .req_ready_o(readyB),
        .q_o(qB), .busy_o(busyB), .pending_o(pendB)
`ifdef EDGE_GENERATOR_OVERFLOW_EN
        , .overflow_o(overflowB)
`endif
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s after edge %0d: got %0d expected %0d", tag, lastEdge, observed, expected);
        end
    endtask

    // Expected outputs follow from the last pulse start and the pending count.
    task automatic checkModel();
        bit expHigh;
        bit expBusy;
        expHigh = (lastEdge >= mLastStart) && (lastEdge < mLastStart + HIGH);
        expBusy = (lastEdge <= mLastStart + HIGH + LOW - 1) || (mPending > 0);
        checkOutput("q", 32'(qA), 32'(expHigh));
        checkOutput("qInv", 32'(qB), 32'(!expHigh));
        checkOutput("busy", 32'(busyA), 32'(expBusy));
        checkOutput("busyInv", 32'(busyB), 32'(expBusy));
        checkOutput("pending", 32'(pendA), 32'(mPending));
        checkOutput("pendingInv", 32'(pendB), 32'(mPending));
        checkOutput("ready", 32'(readyA), 32'(mPending < MAXP));
        checkOutput("readyInv", 32'(readyB), 32'(mPending < MAXP));
`ifdef EDGE_GENERATOR_OVERFLOW_EN
        checkOutput("overflow", 32'(overflowA), 32'(mOverflow));
        checkOutput("overflowInv", 32'(overflowB), 32'(mOverflow));
`endif
    endtask

    // Drive one cycle of request input, advance the model on the edge, check on the falling edge.
    task automatic applyStimulus(input bit valid);
        int t;
        bit ready;
        bit start;
        reqValid = valid;
        @(posedge clock);
        t     = lastEdge + 1;
        ready = (mPending < MAXP);
        start = (mPending > 0) && (t >= mLastStart + HIGH + LOW);
        if (valid && !ready) mOverflow = 1'b1;
        if (start) mLastStart = t;
        mPending = mPending + ((valid && ready) ? 1 : 0) - (start ? 1 : 0);
        lastEdge = t;
        @(negedge clock);
        checkModel();
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
    task automatic applyReset();
        arstN    = 1'b0;
        reqValid = 1'b0;
        #1;
        checkOutput("rstQ", 32'(qA), 32'd0);
        checkOutput("rstQInv", 32'(qB), 32'd1);
        checkOutput("rstPending", 32'(pendA), 32'd0);
        checkOutput("rstBusy", 32'(busyA), 32'd0);
        checkOutput("rstReady", 32'(readyA), 32'd1);
`ifdef EDGE_GENERATOR_OVERFLOW_EN
        checkOutput("rstOverflow", 32'(overflowA), 32'd0);
`endif
        mPending   = 0;
        mLastStart = -1000;
        mOverflow  = 1'b0;
        #1;
        arstN = 1'b1;
    endtask

    initial begin
        int density;
        arstN      = 1'b0;
        reqValid   = 1'b0;
        mPending   = 0;
        mLastStart = -1000;
        mOverflow  = 1'b0;
        lastEdge   = -1;
        @(negedge clock);
        applyReset();

        // Single request straight after reset release.
        applyStimulus(1'b1);
        repeat (12) applyStimulus(1'b0);

        // Three back-to-back requests.
        repeat (3) applyStimulus(1'b1);
        repeat (18) applyStimulus(1'b0);

        // Six requests: queue fills and the last one is dropped.
        repeat (6) applyStimulus(1'b1);
        repeat (32) applyStimulus(1'b0);

        // Reset in the first high cycle of a pulse while two or more requests wait.
        repeat (5) applyStimulus(1'b1);
        for (int i = 0; i < 20; i++) begin
            if ((lastEdge == mLastStart) && (mPending >= 2)) break;
            applyStimulus(1'b0);
        end
        checkOutput("preResetHigh", 32'(qA), 32'd1);
        applyReset();
        repeat (15) applyStimulus(1'b0);

        density = 40;
        for (int i = 0; i < 1200; i++) begin
            if ((i % 60) == 0) begin
                case ($urandom_range(0, 2))
                    0:       density = 10;
                    1:       density = 40;
                    default: density = 90;
                endcase
            end
            if ($urandom_range(0, 199) == 0) applyReset();
            applyStimulus($urandom_range(0, 99) < density);
        end
        repeat (20) applyStimulus(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
